// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller, the extender and the ALU.
// Opcode/funct constants, state and instruction-class enums, select codes.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP  = 4'd0,
    CL_ADDU = 4'd1,
    CL_SUBU = 4'd2,
    CL_ORI  = 4'd3,
    CL_LUI  = 4'd4,
    CL_LW   = 4'd5,
    CL_SW   = 4'd6,
    CL_BEQ  = 4'd7,
    CL_J    = 4'd8,
    CL_ILL  = 4'd9
  } iclass_e;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_SHL2 = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, enables/selects out.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       dm_ready;
  logic       pc_we;
  logic       ir_we;
  logic [1:0] npc_sel;
  logic [1:0] ext_op;
  logic       alu_src;
  logic [2:0] alu_op;
  logic       reg_we;
  logic       reg_dst;
  logic       wd_sel;
  logic       dm_req;
  logic       dm_we;
  logic       illegal;
  logic [2:0] state_o;

  modport master (
    input  opcode, funct, alu_zero, dm_ready,
    output pc_we, ir_we, npc_sel, ext_op, alu_src, alu_op,
           reg_we, reg_dst, wd_sel, dm_req, dm_we, illegal, state_o
  );

  modport slave (
    output opcode, funct, alu_zero, dm_ready,
    input  pc_we, ir_we, npc_sel, ext_op, alu_src, alu_op,
           reg_we, reg_dst, wd_sel, dm_req, dm_we, illegal, state_o
  );
endinterface

// File: rtl/mc_ctrl_instr_dec.sv
// Combinational opcode/funct -> instruction class; anything unrecognised is CL_ILL.
// Zero latency; only consulted by the controller in DECODE.
module instr_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o
);

  always_comb begin
    iclass_o = CL_ILL;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: iclass_o = CL_ADDU;
          FN_SUBU: iclass_o = CL_SUBU;
          FN_NOP:  iclass_o = CL_NOP;
          default: iclass_o = CL_ILL;
        endcase
      end
      OP_ORI:  iclass_o = CL_ORI;
      OP_LUI:  iclass_o = CL_LUI;
      OP_LW:   iclass_o = CL_LW;
      OP_SW:   iclass_o = CL_SW;
      OP_BEQ:  iclass_o = CL_BEQ;
      OP_J:    iclass_o = CL_J;
      default: iclass_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving all datapath enables and selects.
// Moore outputs from state + latched class; MEM stalls until dm_ready, sync reset abandons it.
module mc_ctrl
  import ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  mc_ctrl_if.master bus
);

  state_e  state_q, state_d;
  iclass_e class_q, class_d;
  iclass_e dec_class;

  instr_dec u_dec (
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .iclass_o (dec_class)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RST;
      class_q <= CL_NOP;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  assign bus.state_o = state_q;

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.npc_sel = NPC_PC4;
    bus.ext_op  = EXT_SIGN;
    bus.alu_src = 1'b0;
    bus.alu_op  = ALU_ADD;
    bus.reg_we  = 1'b0;
    bus.reg_dst = 1'b0;
    bus.wd_sel  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.dm_we   = 1'b0;
    bus.illegal = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        bus.ir_we   = 1'b1;
        bus.pc_we   = 1'b1;
        bus.npc_sel = NPC_PC4;
        state_d     = ST_DECODE;
      end

      ST_DECODE: begin
        class_d = dec_class;
        if (dec_class == CL_ILL) begin
          bus.illegal = 1'b1;
          state_d     = ST_FETCH;
        end else if (dec_class == CL_NOP) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (class_q)
          CL_ADDU: begin
            bus.alu_op = ALU_ADD;
            state_d    = ST_WB;
          end
          CL_SUBU: begin
            bus.alu_op = ALU_SUB;
            state_d    = ST_WB;
          end
          CL_ORI: begin
            bus.ext_op  = EXT_ZERO;
            bus.alu_op  = ALU_OR;
            bus.alu_src = 1'b1;
            state_d     = ST_WB;
          end
          CL_LUI: begin
            bus.ext_op  = EXT_LUI;
            bus.alu_op  = ALU_PASSB;
            bus.alu_src = 1'b1;
            state_d     = ST_WB;
          end
          CL_LW, CL_SW: begin
            bus.alu_src = 1'b1;
            state_d     = ST_MEM;
          end
          CL_BEQ: begin
            // Only Mealy term: branch redirect follows the live zero flag.
            bus.ext_op = EXT_SHL2;
            bus.alu_op = ALU_SUB;
            if (bus.alu_zero) begin
              bus.pc_we   = 1'b1;
              bus.npc_sel = NPC_BR;
            end
            state_d = ST_FETCH;
          end
          CL_J: begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_J;
            state_d     = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        // Address path held at its EXEC setting for the whole access.
        bus.alu_src = 1'b1;
        bus.dm_req  = 1'b1;
        bus.dm_we   = (class_q == CL_SW);
        if (bus.dm_ready) begin
          state_d = (class_q == CL_SW) ? ST_FETCH : ST_WB;
        end
      end

      ST_WB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = (class_q == CL_ADDU) || (class_q == CL_SUBU);
        bus.wd_sel  = (class_q == CL_LW);
        state_d     = ST_FETCH;
      end

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected output vectors for each instruction scenario.
module tb_mc_ctrl;
  import ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_we, ir_we, npc_sel, ext_op, alu_src, alu_op, reg_we, reg_dst, wd_sel, dm_req, dm_we, illegal}
  logic [18:0] obs;
  assign obs = {bus.state_o, bus.pc_we, bus.ir_we, bus.npc_sel, bus.ext_op, bus.alu_src,
                bus.alu_op, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.dm_req, bus.dm_we,
                bus.illegal};

  function automatic logic [18:0] ev(input int st, input int pw, input int iw, input int npc,
                                     input int ext, input int as, input int aop, input int rw,
                                     input int rd, input int ws, input int dq, input int dw,
                                     input int il);
    logic [31:0] s, n, x, a;
    s = st; n = npc; x = ext; a = aop;
    return {s[2:0], pw[0], iw[0], n[1:0], x[1:0], as[0], a[2:0], rw[0], rd[0], ws[0],
            dq[0], dw[0], il[0]};
  endfunction

  localparam logic [18:0] V_RST    = 19'd0;
  localparam logic [18:0] V_FETCH  = ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_DEC    = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_DECILL = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  localparam logic [18:0] V_EXORI  = ev(3, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_EXADD  = ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_EXMEM  = ev(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_EXBT   = ev(3, 1, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_EXBN   = ev(3, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_EXJ    = ev(3, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_MEMLW  = ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
  localparam logic [18:0] V_MEMSW  = ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
  localparam logic [18:0] V_WBI    = ev(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  localparam logic [18:0] V_WBR    = ev(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
  localparam logic [18:0] V_WBLW   = ev(5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.alu_zero = 1'b0; bus.dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== V_RST) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, obs, V_RST);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_RST) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, V_RST);
    end
    step();
    checks++;
    if (obs !== V_FETCH) begin
      failures++;
      $display("FAIL reset_first_fetch got=%h exp=%h", obs, V_FETCH);
    end
  endtask

  task automatic test_ori();
    logic [18:0] e [5];
    e = '{V_FETCH, V_DEC, V_EXORI, V_WBI, V_FETCH};
    bus.opcode = OP_ORI; bus.funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL ori[%0d] got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [18:0] e [7];
    logic        az [7];
    e  = '{V_FETCH, V_DEC, V_EXBT, V_FETCH, V_DEC, V_EXBN, V_FETCH};
    az = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.opcode = OP_BEQ;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      bus.alu_zero = az[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL beq[%0d] got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [18:0] e  [8];
    logic        rdy [8];
    e   = '{V_FETCH, V_DEC, V_EXMEM, V_MEMLW, V_MEMLW, V_MEMLW, V_WBLW, V_FETCH};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.opcode = OP_LW;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      bus.dm_ready = rdy[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL lw_wait[%0d] got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_sw_reset_in_mem();
    logic [18:0] e   [10];
    logic        rdy [10];
    logic        rs  [10];
    e   = '{V_FETCH, V_DEC, V_EXMEM, V_MEMSW, V_FETCH, V_DEC, V_EXMEM, V_MEMSW, V_RST, V_FETCH};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.opcode = OP_SW;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      bus.dm_ready = rdy[i];
      reset = rs[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL sw_reset[%0d] got=%h exp=%h", i, obs, e[i]);
      end
    end
    bus.dm_ready = 1'b0;
  endtask

  task automatic test_illegal_nop();
    logic [18:0] e [5];
    e = '{V_FETCH, V_DECILL, V_FETCH, V_DEC, V_FETCH};
    bus.opcode = 6'b111111; bus.funct = 6'b100001;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      if (i == 2) begin
        bus.opcode = OP_RTYPE; bus.funct = FN_NOP;
      end
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL illegal_nop[%0d] got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // addu whose IR changes to a j after DECODE: latched class must still be addu.
    logic [18:0] e [8];
    e = '{V_FETCH, V_DEC, V_EXADD, V_WBR, V_FETCH, V_DEC, V_EXJ, V_FETCH};
    bus.opcode = OP_RTYPE; bus.funct = FN_ADDU;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (i == 2) begin
        bus.opcode = OP_J; bus.funct = 6'd0;
      end
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_ori();
    test_beq();
    test_lw_wait();
    test_sw_reset_in_mem();
    test_illegal_nop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the single-issue MIPS-subset CPU datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-cycle enables and selects for the PC, IR, immediate extender, ALU, register file and data memory. It includes a request/ready handshake toward data memory. It sits beside the datapath top and is the only source of those datapath control signals.

## Interface
- No parameters; opcode, funct, state and select encodings are fixed constants in the shared package.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- opcode  in  6  IR[31:26], valid from the DECODE cycle onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- dm_ready  in  1  data memory completion for the current dm_req
- pc_we  out  1  PC write enable
- ir_we  out  1  IR write enable
- npc_sel  out  2  next PC: 00 pc+4, 01 branch (pc+ext), 10 jump (pc[31:28],instr_index,00)
- ext_op  out  2  extender mode: 00 sign, 01 zero, 10 lui (imm<<16), 11 sign<<2
- alu_src  out  1  0 = rt, 1 = extended immediate
- alu_op  out  3  000 add, 001 sub, 010 or, 011 pass B
- reg_we  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- wd_sel  out  1  0 = ALU result, 1 = memory data
- dm_req  out  1  data memory request
- dm_we  out  1  data memory write (qualifies dm_req)
- illegal  out  1  one-cycle pulse on an unsupported encoding
- state_o  out  3  current state, for debug and bench

## Operation
- Supported instructions: addu (R, funct 100001), subu (R, funct 100011), nop (R, funct 000000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010. Everything else is illegal.
- States: RST, FETCH, DECODE, EXEC, MEM, WB.
- RST: all outputs 0; go to FETCH on the first cycle with reset=1.
- FETCH: ir_we=1, pc_we=1, npc_sel=00; go to DECODE.
- DECODE: latch the instruction class from opcode/funct into a class register.
  - nop → FETCH.
  - illegal → illegal=1, then FETCH.
  - any other class → EXEC.
- EXEC: ext_op, alu_src and alu_op are driven from the class.
  - addu: alu_op=000, alu_src=0 → WB.
  - subu: alu_op=001, alu_src=0 → WB.
  - ori: ext_op=01, alu_op=010, alu_src=1 → WB.
  - lui: ext_op=10, alu_op=011, alu_src=1 → WB.
  - lw/sw: ext_op=00, alu_op=000, alu_src=1 → MEM.
  - beq: ext_op=11, alu_op=001, alu_src=0. If alu_zero=1: pc_we=1, npc_sel=01. Then → FETCH.
  - j: pc_we=1, npc_sel=10 → FETCH.
- MEM: dm_req=1 held; dm_we=1 for sw. ext_op, alu_src and alu_op are held at their EXEC values.
  - Remain in MEM while dm_ready=0.
  - When dm_ready=1: sw → FETCH, lw → WB.
- WB: reg_we=1.
  - addu/subu: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
  - Then → FETCH.
- Outputs are Moore-style: decoded from state and the class register only. The exception is the beq pc_we, which also depends on alu_zero.
- Outputs not listed for a state are 0.

## Timing
- Cycles per instruction:
  - nop, illegal: 2
  - beq, j: 3
  - addu, subu, ori, lui: 4
  - sw: 4 + wait cycles
  - lw: 5 + wait cycles
  - Wait cycles = MEM cycles with dm_ready=0.
- dm_ready=1 in the first MEM cycle gives a single-cycle MEM.
- dm_ready outside MEM is ignored.
- opcode and funct are sampled only in DECODE; later IR changes do not affect the latched class.
- reset=0 in any state, including MEM with dm_req high:
  - next state is RST;
  - all outputs are 0 from the following cycle;
  - a pending memory request is abandoned, never completed.
- Holding reset=0 keeps the block in RST. FETCH occurs exactly one cycle after reset rises.

## Structure
- Package ctrl_pkg holds:
  - opcode and funct constants;
  - state encoding (RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5);
  - instruction class enum;
  - ext_op, alu_op and npc_sel codes, shared with the extender and ALU.
- Sub-module instr_dec: combinational opcode/funct → class (including illegal). Used once, in DECODE.

## Test plan
- Reset held 3 cycles, then released → state_o = 0 (RST) and all outputs 0 while held; FETCH with ir_we=pc_we=1 exactly one cycle after release.
- ori (opcode 001101) → sequence FETCH, DECODE, EXEC (ext_op=01, alu_src=1, alu_op=010), WB (reg_we=1, reg_dst=0, wd_sel=0); next FETCH at cycle 5.
- beq with alu_zero=1, then with alu_zero=0 → EXEC has ext_op=11 in both cases; pc_we=1/npc_sel=01 in the taken case only; FETCH follows EXEC in both.
- lw with dm_ready low for 2 MEM cycles → dm_req=1, dm_we=0 for 3 cycles, then WB with wd_sel=1 and reg_we=1; 7 cycles total.
- sw with dm_ready=1 in the first MEM cycle, then reset=0 asserted during a second sw's MEM cycle → first sw: dm_we=1 for one cycle, then FETCH; second sw: dm_req drops and state_o=0 on the next cycle.
- opcode 111111 → illegal pulses once in DECODE and FETCH follows; funct 000000 (nop) → DECODE straight to FETCH with no reg_we.
